// File: rtl/ram_dp_pkg.sv
// Shared widths and init-FSM state type for the dual-port RAM slice.
package InstructionStruct;

    localparam int DWIDTH = 32;
    localparam int AWIDTH = 10;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } ram_init_state_t;

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-latency pipeline: valid and data stages, each data stage loads only behind a valid.
module ram_rd_pipe #(
    parameter int DWIDTH = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inVld,
    input  logic [DWIDTH-1:0] inData,
    output logic              rdValid,
    output logic [DWIDTH-1:0] rdData
);

    logic [RD_LAT:1]             vld_pipe;
    logic [RD_LAT:1][DWIDTH-1:0] dat_pipe;

    // Data stages only load on a valid so the last stage holds between results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= inVld;
            if (inVld) dat_pipe[1] <= inData;
            for (int i = 2; i <= RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign rdValid = vld_pipe[RD_LAT];
    assign rdData  = dat_pipe[RD_LAT];

endmodule

// File: rtl/ram_dp.sv
// Simple dual-port RAM (write port A, read port B) with self-initialisation and byte enables.
module ram_dp #(
    parameter int                         DWIDTH   = InstructionStruct::DWIDTH,
    parameter int                         AWIDTH   = InstructionStruct::AWIDTH,
    parameter int                         RD_LAT   = 1,
    parameter logic [DWIDTH-1:0]          INIT_VAL = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                ready,
    input  logic                wrEn,
    input  logic [AWIDTH-1:0]   wrAddr,
    input  logic [DWIDTH-1:0]   wrData,
    input  logic [DWIDTH/8-1:0] wrBe,
    input  logic                rdEn,
    input  logic [AWIDTH-1:0]   rdAddr,
    output logic [DWIDTH-1:0]   rdData,
    output logic                rdValid
);

    import InstructionStruct::*;

    localparam int DEPTH  = 1 << AWIDTH;
    localparam int NBYTES = DWIDTH / 8;

    if (DWIDTH % 8 != 0) begin : g_dw_err
        $error("ram_dp: DWIDTH must be a multiple of 8");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_lat_err
        $error("ram_dp: RD_LAT must be 1 or 2");
    end

    ram_init_state_t   state;
    logic [AWIDTH-1:0] initCnt;
    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DWIDTH-1:0] wr_word;
    logic [DWIDTH-1:0] rd_word;
    logic              wr_go;
    logic              rd_go;

    // initCnt stops counting once READY, so wrapping can never restart init.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= INIT;
            initCnt <= '0;
        end else if (state == INIT) begin
            initCnt <= initCnt + 1'b1;
            if (initCnt == {AWIDTH{1'b1}}) state <= READY;
        end
    end

    assign ready = (state == READY);
    assign wr_go = ready & wrEn;
    assign rd_go = ready & rdEn;

    always_comb begin
        wr_word = mem[wrAddr];
        for (int b = 0; b < NBYTES; b++)
            if (wrBe[b]) wr_word[b*8 +: 8] = wrData[b*8 +: 8];
    end

    // Write-first: a same-address read sees the byte-merged word of this edge.
    assign rd_word = (wr_go && wrAddr == rdAddr) ? wr_word : mem[rdAddr];

    always_ff @(posedge clk) begin
        if (state == INIT)
            mem[initCnt] <= INIT_VAL;
        else if (wr_go)
            mem[wrAddr] <= wr_word;
    end

    ram_rd_pipe #(
        .DWIDTH (DWIDTH),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .reset   (reset),
        .inVld   (rd_go),
        .inData  (rd_word),
        .rdValid (rdValid),
        .rdData  (rdData)
    );

endmodule

// File: tb/tb_ram_dp.sv
// Randomised bench for ram_dp: RD_LAT=1 and RD_LAT=2 instances share stimulus, one array model.
module tb_ram_dp;

    logic        clk = 1'b0;
    logic        reset;
    logic        wrEn, rdEn;
    logic [3:0]  wrAddr, rdAddr;
    logic [15:0] wrData;
    logic [1:0]  wrBe;
    logic        ready1, ready2, rdValid1, rdValid2;
    logic [15:0] rdData1, rdData2;

    always #5 clk = ~clk;

    ram_dp #(.DWIDTH(16), .AWIDTH(4), .RD_LAT(1), .INIT_VAL(16'h0000)) u_lat1 (
        .clk(clk), .reset(reset), .ready(ready1),
        .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .wrBe(wrBe),
        .rdEn(rdEn), .rdAddr(rdAddr), .rdData(rdData1), .rdValid(rdValid1)
    );

    ram_dp #(.DWIDTH(16), .AWIDTH(4), .RD_LAT(2), .INIT_VAL(16'h0000)) u_lat2 (
        .clk(clk), .reset(reset), .ready(ready2),
        .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .wrBe(wrBe),
        .rdEn(rdEn), .rdAddr(rdAddr), .rdData(rdData2), .rdValid(rdValid2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: word array, edge count since reset, per-edge read history.
    bit [15:0] mdl [16];
    bit        mdl_ready;
    int        init_edges;
    bit        hist_v [$];
    bit [15:0] hist_d [$];
    bit [15:0] hold [1:2];

    task automatic mdl_reset();
        for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
        mdl_ready  = 1'b0;
        init_edges = 0;
        hist_v.delete();
        hist_d.delete();
        hold[1] = 16'h0000;
        hold[2] = 16'h0000;
    endtask

    task automatic idle();
        wrEn = 0; wrAddr = 0; wrData = 0; wrBe = 0; rdEn = 0; rdAddr = 0;
    endtask

    // Drive one cycle from a negedge, advance the model on the edge, check #1 later.
    task automatic step(input bit we, input bit [3:0] wa, input bit [15:0] wd,
                        input bit [1:0] be, input bit re, input bit [3:0] ra);
        bit ev;
        bit [15:0] ed;
        wrEn = we; wrAddr = wa; wrData = wd; wrBe = be; rdEn = re; rdAddr = ra;
        @(posedge clk);
        if (mdl_ready) begin
            if (we) begin
                if (be[0]) mdl[wa][7:0]  = wd[7:0];
                if (be[1]) mdl[wa][15:8] = wd[15:8];
            end
            hist_v.push_back(re);
            hist_d.push_back(mdl[ra]);
        end else begin
            init_edges++;
            hist_v.push_back(1'b0);
            hist_d.push_back(16'h0000);
            if (init_edges == 16) mdl_ready = 1'b1;
        end
        #1;
        chk("ready_lat1", {31'b0, ready1}, {31'b0, mdl_ready});
        chk("ready_lat2", {31'b0, ready2}, {31'b0, mdl_ready});
        for (int l = 1; l <= 2; l++) begin
            ev = (hist_v.size() >= l) ? hist_v[hist_v.size()-l] : 1'b0;
            ed = (hist_v.size() >= l) ? hist_d[hist_d.size()-l] : 16'h0000;
            if (ev) hold[l] = ed;
            if (l == 1) begin
                chk("rdValid_lat1", {31'b0, rdValid1}, {31'b0, ev});
                chk("rdData_lat1", {16'b0, rdData1}, {16'b0, hold[1]});
            end else begin
                chk("rdValid_lat2", {31'b0, rdValid2}, {31'b0, ev});
                chk("rdData_lat2", {16'b0, rdData2}, {16'b0, hold[2]});
            end
        end
        @(negedge clk);
    endtask

    task automatic reset_cycle(input int n);
        reset = 1'b1;
        mdl_reset();
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        mdl_reset();
        #1;
        chk("rst_ready", {31'b0, ready1 | ready2}, 32'd0);
        chk("rst_valid", {31'b0, rdValid1 | rdValid2}, 32'd0);
        chk("rst_data", {16'b0, rdData1 | rdData2}, 32'd0);
        reset_cycle(3);

        // Init phase: writes to addr 2 and random reads must be ignored.
        for (int i = 0; i < 16; i++)
            step(1'b1, 4'd2, 16'h5555, 2'b11, 1'($urandom_range(0, 1)), 4'($urandom));

        for (int a = 0; a < 16; a++) step(0, 0, 0, 0, 1'b1, 4'(a));
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        step(1, 4'd3, 16'hA5A5, 2'b11, 0, 0);
        step(0, 0, 0, 0, 1, 4'd3);
        step(1, 4'd5, 16'h1234, 2'b11, 0, 0);
        step(1, 4'd5, 16'hFF00, 2'b10, 0, 0);
        step(0, 0, 0, 0, 1, 4'd5);
        step(1, 4'd7, 16'hBEEF, 2'b11, 1, 4'd7);
        step(1, 4'd9, 16'hC3C3, 2'b01, 1, 4'd9);
        step(1, 4'd9, 16'h7777, 2'b00, 1, 4'd9);
        step(0, 0, 0, 0, 1, 4'd2);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom), 2'($urandom),
                 1'($urandom_range(0, 3) != 0), 4'($urandom));

        // Reset in the middle of a read burst: outputs must drop with no clock edge.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 4'(i + 8));
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_ready", {30'b0, ready1, ready2}, 32'd0);
        chk("async_rst_valid", {30'b0, rdValid1, rdValid2}, 32'd0);
        chk("async_rst_data", {rdData1, rdData2}, 32'd0);
        @(negedge clk);
        reset_cycle(2);

        for (int i = 0; i < 16; i++) step(1'b1, 4'd3, 16'h9999, 2'b11, 1'b1, 4'd3);
        step(0, 0, 0, 0, 1, 4'd3);
        for (int i = 0; i < 100; i++)
            step(1'($urandom_range(0, 1)), 4'($urandom), 16'($urandom), 2'($urandom),
                 1'($urandom_range(0, 1)), 4'($urandom));
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_dp.md
RAM_DP -- requirements
Module: ram_dp

Interface
REQ-001 Parameter DWIDTH, default InstructionStruct::DWIDTH, data word width in bits; SHALL be a multiple of 8 (elaboration error otherwise).
REQ-002 Parameter AWIDTH, default InstructionStruct::AWIDTH, address width; depth = 2^AWIDTH words.
REQ-003 Parameter RD_LAT, default 1, read latency in cycles; legal values 1 or 2 (elaboration error otherwise).
REQ-004 Parameter INIT_VAL, default 0, DWIDTH-bit value written to every word during initialisation.
REQ-005 One clock; reset is asynchronous and active-high (ports clk, reset).
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 ready  out  1  high when initialisation is complete and ports accept requests.
REQ-009 wrEn  in  1  write request, port A.
REQ-010 wrAddr  in  AWIDTH  write address.
REQ-011 wrData  in  DWIDTH  write data.
REQ-012 wrBe  in  DWIDTH/8  byte write enables; bit i covers wrData[8i+7:8i].
REQ-013 rdEn  in  1  read request, port B.
REQ-014 rdAddr  in  AWIDTH  read address.
REQ-015 rdData  out  DWIDTH  read data.
REQ-016 rdValid  out  1  rdData carries the result of a read issued RD_LAT cycles earlier.

Function
REQ-017 Two states: INIT and READY; ready SHALL be 1 only in READY.
REQ-018 In INIT, each clk edge writes INIT_VAL to mem[initCnt] and increments initCnt; on the edge writing address 2^AWIDTH-1 the state SHALL move to READY, so ready rises exactly 2^AWIDTH edges after reset deasserts.
REQ-019 In INIT, wrEn and rdEn SHALL be ignored: no memory change, no rdValid pulse.
REQ-020 In READY, on an edge with wrEn=1, each byte of mem[wrAddr] with wrBe bit set SHALL take the wrData byte; other bytes unchanged; wrBe=0 SHALL leave memory unchanged.
REQ-021 In READY, rdEn=1 sampled at edge N SHALL produce rdValid=1 and rdData=mem[rdAddr] after edge N+RD_LAT-1+1 (i.e. RD_LAT edges later), one result per request, full throughput (one read per cycle).
REQ-022 Read and write to the same address on the same edge SHALL return the new, byte-merged word (write-first).
REQ-023 Independent addresses on the same edge SHALL both complete with no interaction.
REQ-024 rdData SHALL hold its last value while rdValid=0.
REQ-025 Address wrap: initCnt is AWIDTH bits and SHALL not be used after reaching READY; no wrap re-triggers INIT.

Reset
REQ-026 reset=1 SHALL immediately (asynchronously) set state INIT, initCnt 0, ready 0, rdValid 0, rdData 0, and flush all in-flight reads.
REQ-027 Reset asserted mid-operation (INIT or READY) SHALL restart a full initialisation after deassertion; memory contents are then INIT_VAL everywhere.

Structure
REQ-028 DWIDTH, AWIDTH and the state enum (ram_init_state_t: INIT, READY) SHALL live in package InstructionStruct.
REQ-029 The read-latency pipeline (valid/data stages, RD_LAT 1 or 2) SHALL be a sub-module ram_rd_pipe; the storage array and init FSM stay in ram_dp.

Verification (bench: DWIDTH=16, AWIDTH=4, INIT_VAL=0, run RD_LAT=1 and 2)
REQ-030 Release reset -> ready rises exactly 16 edges later; read addresses 0..15 back-to-back -> 16 consecutive rdValid pulses, all rdData 0x0000.
REQ-031 Write 0xA5A5 to addr 3, wrBe=2'b11; read addr 3 -> rdData 0xA5A5 with rdValid RD_LAT edges after request.
REQ-032 Write 0x1234 to addr 5, then 0xFF00 with wrBe=2'b10; read addr 5 -> 0xFF34.
REQ-033 Same edge: write 0xBEEF to addr 7, read addr 7 -> rdData 0xBEEF.
REQ-034 wrEn=1, addr 2, 0x5555 during INIT -> after ready, read addr 2 returns 0x0000, no rdValid during INIT.
REQ-035 Assert reset during a read burst -> rdValid and ready drop in the same timestep without a clock edge; after re-init, addr 3 reads 0x0000.
